// File: rtl/main_decoder.sv
// ----------------------------------------------------------------------------
// riscv_pkg / main_decoder
//
// Main control decoder of the rv32i Decode stage. Turns the 7-bit major
// opcode into the datapath control bundle and the 2-bit ALUOp that feeds the
// ALU decoder. Decoding is purely combinational; a single clocked bit keeps a
// sticky record of any unsupported opcode for debug and trap logic.
//
// Ports:
//   clk          in   1       system clock (sticky flag only)
//   rst          in   1       synchronous, active-high reset (sticky flag only)
//   opcode       in   7       instr[6:0]
//   ctrl         out  ctrl_s  datapath control bundle
//   alu_op       out  2       00 add, 01 subtract/compare, 10 use funct3/funct7
//   illegal      out  1       opcode is not one of the six supported ones
//   illegal_seen out  1       sticky OR of illegal since the last reset
// ----------------------------------------------------------------------------

package riscv_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      IMM_I = 2'd0,
      IMM_S = 2'd1,
      IMM_B = 2'd2,
      IMM_J = 2'd3
   } imm_src_e;

   // ResultSrc: 00 ALU result, 01 memory read data, 10 PC+4, 11 unused.
   typedef struct packed {
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic       MemWrite;
      logic       Jump;
      logic       Branch;
      logic       ALUSrc;
      imm_src_e   ImmSrc;
   } ctrl_s;

endpackage : riscv_pkg

module main_decoder
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   output ctrl_s      ctrl,
   output logic [1:0] alu_op,
   output logic       illegal,
   output logic       illegal_seen
);

   logic illegal_seen_q;
   logic illegal_seen_d;

   // Opcode decode: every output gets a safe "no side effect" default first so
   // unsupported opcodes (and any future opcode) can never write state.
   always_comb begin
      ctrl.RegWrite  = 1'b0;
      ctrl.ResultSrc = 2'b00;
      ctrl.MemWrite  = 1'b0;
      ctrl.Jump      = 1'b0;
      ctrl.Branch    = 1'b0;
      ctrl.ALUSrc    = 1'b0;
      ctrl.ImmSrc    = IMM_I;
      alu_op         = 2'b00;
      illegal        = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            ctrl.RegWrite = 1'b1;
            alu_op        = 2'b10;
         end
         OP_ITYPE: begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            alu_op        = 2'b10;
         end
         OP_LOAD: begin
            ctrl.RegWrite  = 1'b1;
            ctrl.ResultSrc = 2'b01;
            ctrl.ALUSrc    = 1'b1;
         end
         OP_STORE: begin
            ctrl.MemWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.ImmSrc   = IMM_S;
         end
         OP_BRANCH: begin
            ctrl.Branch = 1'b1;
            ctrl.ImmSrc = IMM_B;
            alu_op      = 2'b01;
         end
         OP_JAL: begin
            // Link register gets PC+4; the target adder uses the J immediate.
            ctrl.RegWrite  = 1'b1;
            ctrl.ResultSrc = 2'b10;
            ctrl.Jump      = 1'b1;
            ctrl.ImmSrc    = IMM_J;
         end
         default: begin
            // JALR, LUI, AUIPC, FENCE, SYSTEM and all others are unsupported.
            illegal = 1'b1;
         end
      endcase
   end

   // Sticky flag next state: once set it holds until reset.
   always_comb begin
      illegal_seen_d = illegal_seen_q | illegal;
   end

   // Sticky flag register; reset takes priority over a simultaneous illegal.
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_seen_q <= 1'b0;
      end else begin
         illegal_seen_q <= illegal_seen_d;
      end
   end

   assign illegal_seen = illegal_seen_q;

endmodule : main_decoder

// File: tb/tb_main_decoder.sv
module tb_main_decoder;
   import riscv_pkg::*;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   ctrl_s      ctrl;
   logic [1:0] alu_op;
   logic       illegal;
   logic       illegal_seen;

   main_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .ctrl         (ctrl),
      .alu_op       (alu_op),
      .illegal      (illegal),
      .illegal_seen (illegal_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       kind;   // 0: decode check, 1: sticky flag check
      logic [6:0] op;
      ctrl_s      ctrl;
      logic [1:0] alu;
      logic       ill;
      logic       seen;
   } sb_item_t;

   sb_item_t exp_q[$];
   event     sample_ev;
   int       chk_cnt  = 0;
   int       pass_cnt = 0;
   logic     ill_by_op [128];

   task automatic check(input string name, input logic ok, input string detail);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   // Hand-written expectation table for the six supported opcodes.
   function automatic sb_item_t exp_dec(input logic [6:0] op);
      sb_item_t e;
      e.kind = 1'b0; e.op = op; e.seen = 1'b0;
      e.ctrl.RegWrite = 1'b0; e.ctrl.ResultSrc = 2'b00; e.ctrl.MemWrite = 1'b0;
      e.ctrl.Jump = 1'b0; e.ctrl.Branch = 1'b0; e.ctrl.ALUSrc = 1'b0;
      e.ctrl.ImmSrc = IMM_I; e.alu = 2'b00; e.ill = 1'b1;
      case (op)
         7'b0110011: begin e.ctrl.RegWrite = 1'b1; e.alu = 2'b10; e.ill = 1'b0; end
         7'b0010011: begin e.ctrl.RegWrite = 1'b1; e.ctrl.ALUSrc = 1'b1; e.alu = 2'b10; e.ill = 1'b0; end
         7'b0000011: begin e.ctrl.RegWrite = 1'b1; e.ctrl.ResultSrc = 2'b01; e.ctrl.ALUSrc = 1'b1; e.ill = 1'b0; end
         7'b0100011: begin e.ctrl.MemWrite = 1'b1; e.ctrl.ALUSrc = 1'b1; e.ctrl.ImmSrc = IMM_S; e.ill = 1'b0; end
         7'b1100011: begin e.ctrl.Branch = 1'b1; e.ctrl.ImmSrc = IMM_B; e.alu = 2'b01; e.ill = 1'b0; end
         7'b1101111: begin e.ctrl.RegWrite = 1'b1; e.ctrl.ResultSrc = 2'b10; e.ctrl.Jump = 1'b1;
                           e.ctrl.ImmSrc = IMM_J; e.ill = 1'b0; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic issue_dec(input logic [6:0] op);
      opcode = op;
      exp_q.push_back(exp_dec(op));
      #1;
      -> sample_ev;
      #1;
   endtask

   task automatic issue_seen(input logic s);
      sb_item_t e;
      e = exp_dec(opcode);
      e.kind = 1'b1;
      e.seen = s;
      exp_q.push_back(e);
      #1;
      -> sample_ev;
      #1;
   endtask

   // Monitor: pops the next expectation whenever the bench strobes a sample.
   always @(sample_ev) begin
      sb_item_t it;
      if (exp_q.size() == 0) begin
         check("underflow", 1'b0, "sample strobe with empty scoreboard");
      end else begin
         it = exp_q.pop_front();
         if (it.kind == 1'b0) begin
            check("decode", (ctrl === it.ctrl) && (alu_op === it.alu) && (illegal === it.ill),
                  $sformatf("op=%b got ctrl=%h alu=%b ill=%b, want ctrl=%h alu=%b ill=%b",
                            it.op, ctrl, alu_op, illegal, it.ctrl, it.alu, it.ill));
            check("no_x", !$isunknown({ctrl, alu_op, illegal, illegal_seen}),
                  $sformatf("op=%b got ctrl=%h alu=%b ill=%b seen=%b, want no X",
                            it.op, ctrl, alu_op, illegal, illegal_seen));
            check("invariant", !(ctrl.MemWrite && ctrl.RegWrite) && !(ctrl.Jump && ctrl.Branch)
                               && (ctrl.ResultSrc !== 2'b11),
                  $sformatf("op=%b got ctrl=%h, want exclusive MemWrite/RegWrite and Jump/Branch",
                            it.op, ctrl));
            ill_by_op[it.op] = (illegal === 1'b1);
         end else begin
            check("illegal_seen", illegal_seen === it.seen,
                  $sformatf("op=%b got %b, want %b", opcode, illegal_seen, it.seen));
         end
      end
   end

   initial begin
      int n_ill;
      for (int i = 0; i < 128; i++) ill_by_op[i] = 1'b0;
      rst    = 1'b1;
      opcode = 7'b0110011;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue_seen(1'b0);                 // reset state

      // Supported opcodes, one clock apart; sticky flag must stay clear.
      @(negedge clk); issue_dec(7'b0110011);
      @(negedge clk); issue_dec(7'b0010011);
      @(negedge clk); issue_dec(7'b0000011);
      @(negedge clk); issue_dec(7'b0100011);
      @(negedge clk); issue_dec(7'b1100011);
      @(negedge clk); issue_dec(7'b1101111);
      @(negedge clk); issue_seen(1'b0);

      // Illegal opcodes set the sticky flag; reset clears it despite illegal.
      @(negedge clk); issue_dec(7'b0000000);
      @(negedge clk); issue_seen(1'b1);
      issue_dec(7'b1100111);
      rst = 1'b1;
      @(negedge clk); issue_seen(1'b0);
      rst = 1'b0;
      @(negedge clk); issue_seen(1'b1);  // relatches while opcode still illegal

      // Full sweep.
      for (int i = 0; i < 128; i++) issue_dec(i[6:0]);

      for (int w = 0; w < 100 && exp_q.size() != 0; w++) #1;
      check("drain", exp_q.size() == 0, $sformatf("got %0d pending, want 0", exp_q.size()));

      n_ill = 0;
      for (int i = 0; i < 128; i++) if (ill_by_op[i]) n_ill++;
      check("illegal_count", n_ill == 122, $sformatf("got %0d, want 122", n_ill));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_main_decoder

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Main control decoder of the rv32i pipeline, located in the Decode stage.
- Maps the 7-bit instruction opcode to the datapath control bundle (ctrl_s from riscv_pkg) and to the 2-bit ALUOp that feeds the ALU decoder.
- The decode path is purely combinational.
- A small clocked block adds a sticky illegal-opcode flag for debug and trap logic.

Parameters:
- none; opcode constants (OP_*), ctrl_s and imm_src_e come from riscv_pkg.

Ports:
- clk  in  1  system clock; used only by the sticky flag.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0].
- ctrl  out  ctrl_s  control bundle. Fields:
  - RegWrite (1)
  - ResultSrc (2)
  - MemWrite (1)
  - Jump (1)
  - Branch (1)
  - ALUSrc (1)
  - ImmSrc (imm_src_e)
- alu_op  out  2  00 = add (address calc), 01 = subtract/compare (branch), 10 = decode from funct3/funct7.
- illegal  out  1  combinational; high when opcode is not one of the six supported opcodes.
- illegal_seen  out  1  registered; sticky OR of illegal.

Behaviour:
- ResultSrc encoding:
  - 00 = ALU result
  - 01 = memory read data
  - 10 = PC+4
  - 11 = unused, never driven.
- imm_src_e values: IMM_I, IMM_S, IMM_B, IMM_J.
- Field order for each opcode below: RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ImmSrc, alu_op.
  - OP_RTYPE 0110011: 1, 00, 0, 0, 0, 0, IMM_I, 10.
  - OP_ITYPE 0010011: 1, 00, 0, 0, 0, 1, IMM_I, 10.
  - OP_LOAD 0000011: 1, 01, 0, 0, 0, 1, IMM_I, 00.
  - OP_STORE 0100011: 0, 00, 1, 0, 0, 1, IMM_S, 00.
  - OP_BRANCH 1100011: 0, 00, 0, 0, 1, 0, IMM_B, 01.
  - OP_JAL 1101111: 1, 10, 0, 1, 0, 0, IMM_J, 00.
- Any other opcode (including 0000000, JALR, LUI, AUIPC, FENCE, SYSTEM):
  - all ctrl fields 0, ImmSrc = IMM_I, alu_op = 00;
  - illegal = 1.
- Outputs never carry X for any opcode: full default assignment before the case statement.
- Combinational path: outputs are valid within the same delta after opcode changes; no clock is involved.
- Invariants for every opcode:
  - MemWrite and RegWrite are never both 1.
  - Jump and Branch are never both 1.
- illegal_seen:
  - rst = 1 at a rising clk edge: illegal_seen <= 0. Reset wins over a simultaneous illegal.
  - Otherwise: illegal_seen <= illegal_seen | illegal.
  - Power-up value is undefined until the first reset.
- rst and clk have no effect on ctrl, alu_op or illegal.

Test Plan:
- opcode = 0110011 -> RegWrite 1, ResultSrc 00, ALUSrc 0, alu_op 10, MemWrite/Jump/Branch 0, illegal 0.
- opcode = 0010011 -> RegWrite 1, ResultSrc 00, ALUSrc 1, ImmSrc IMM_I, alu_op 10. Then opcode = 0000011 -> RegWrite 1, ResultSrc 01, ALUSrc 1, ImmSrc IMM_I, alu_op 00.
- opcode = 0100011 -> MemWrite 1, RegWrite 0, ALUSrc 1, ImmSrc IMM_S, alu_op 00. Then opcode = 1100011 -> Branch 1, ALUSrc 0, ImmSrc IMM_B, alu_op 01.
- opcode = 1101111 -> Jump 1, RegWrite 1, ResultSrc 10, ImmSrc IMM_J, alu_op 00, Branch 0.
- opcode = 0000000 and opcode = 1100111 -> all ctrl 0, alu_op 00, illegal 1. After one clk edge with rst = 0, illegal_seen = 1. Then rst = 1 for one edge -> illegal_seen = 0, even while opcode remains illegal.
- Sweep all 128 opcodes -> no X on any output; the invariants hold; illegal = 1 exactly for the 122 opcodes outside the six supported ones.
